// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC, byte-wide instruction fetch, IF/ID register and NOP-run halt
// Little-endian word assembly from a byte array; fetches past the array end read as zero.
module instruction_fetch_stage #(
  parameter int          MEM_BYTES      = 256,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          NOP_HALT_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction_mem [MEM_BYTES],
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] next_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misaligned_fault
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [3:0] NOP_LIMIT = 4'(NOP_HALT_COUNT);

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [3:0]  nop_cnt_q, nop_cnt_d;

  logic [32:0]   last_byte_addr;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   fetch_word;
  logic [31:0]   pc_inc;
  logic [3:0]    nop_inc;
  logic          redirect_ok;

  // The 33-bit sum keeps a PC near 2^32 from wrapping back into range.
  assign last_byte_addr = {1'b0, pc_q} + 33'd3;
  assign in_range       = last_byte_addr < 33'(MEM_BYTES);
  assign idx            = pc_q[AW-1:0];
  assign fetch_word     = in_range ? {instruction_mem[idx + AW'(3)], instruction_mem[idx + AW'(2)],
                                      instruction_mem[idx + AW'(1)], instruction_mem[idx]}
                                   : 32'h0;
  assign pc_inc         = pc_q + 32'd4;
  assign nop_inc        = nop_cnt_q + 4'd1;
  assign redirect_ok    = redirect && (redirect_pc[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    nop_cnt_d  = nop_cnt_q;
    if (state_q == ST_HALT) begin
      instr_d    = 32'h0;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (redirect_ok) begin
      pc_d       = redirect_pc;
      instr_d    = 32'h0;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
      nop_cnt_d  = 4'd0;
    end else begin
      if (redirect) fault_d = 1'b1;
      if (stall) begin
        if (flush) begin
          instr_d    = 32'h0;
          pc_plus4_d = 32'h0;
          valid_d    = 1'b0;
        end
      end else if (flush) begin
        instr_d    = 32'h0;
        pc_plus4_d = 32'h0;
        valid_d    = 1'b0;
        pc_d       = pc_inc;
      end else begin
        instr_d    = fetch_word;
        pc_plus4_d = pc_inc;
        valid_d    = 1'b1;
        pc_d       = pc_inc;
        if (fetch_word == 32'h0) begin
          nop_cnt_d = nop_inc;
          // The NOP that completes the run is still delivered to IF/ID.
          if (nop_inc == NOP_LIMIT) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end else begin
          nop_cnt_d = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      nop_cnt_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      nop_cnt_q  <= nop_cnt_d;
    end
  end

  assign pc               = pc_q;
  assign next_instruction = instr_q;
  assign if_id_pc_plus4   = pc_plus4_q;
  assign if_id_valid      = valid_q;
  assign halted           = halted_q;
  assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset;
  logic [7:0]  mem [256];
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] next_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        misaligned_fault;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_stage #(
    .MEM_BYTES(256),
    .RESET_PC(32'h0000_0000),
    .NOP_HALT_COUNT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instruction_mem(mem),
    .stall(stall),
    .flush(flush),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .pc(pc),
    .next_instruction(next_instruction),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid),
    .halted(halted),
    .misaligned_fault(misaligned_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int addr, input logic [31:0] w);
    mem[addr]   = w[7:0];
    mem[addr+1] = w[15:8];
    mem[addr+2] = w[23:16];
    mem[addr+3] = w[31:24];
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pp4,
                            input logic e_valid, input logic [31:0] e_pc);
    check({tag, "_instr"}, next_instruction, e_instr);
    check({tag, "_pp4"}, if_id_pc_plus4, e_pp4);
    check({tag, "_valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
    check({tag, "_pc"}, pc, e_pc);
  endtask

  task automatic check_reset_state(input string tag);
    check_ifid(tag, 32'h0, 32'h0, 1'b0, 32'h0);
    check({tag, "_halted"}, {31'h0, halted}, 32'h0);
    check({tag, "_fault"}, {31'h0, misaligned_fault}, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    clear_mem();
    set_word(32'h00, 32'h200A000A);
    set_word(32'h04, 32'h200C000B);
    set_word(32'h08, 32'h12345678);
    set_word(32'h0C, 32'h11111111);
    set_word(32'h10, 32'h22222222);
    set_word(32'h14, 32'h018A5820);
    set_word(32'h18, 32'h33333333);
    set_word(32'h1C, 32'h44444444);
    #12;
    check_reset_state("rst");
    @(negedge clk) reset = 1'b1;

    step();
    check_ifid("e1", 32'h200A000A, 32'h4, 1'b1, 32'h4);
    check("e1_le_byte3", {24'h0, mem[3]}, 32'h20);
    step();
    check_ifid("e2", 32'h200C000B, 32'h8, 1'b1, 32'h8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 32'h200C000B, 32'h8, 1'b1, 32'h8);
    end
    stall = 1'b0;
    step();
    check_ifid("unstall", 32'h12345678, 32'hC, 1'b1, 32'hC);

    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h14;
    step();
    check_ifid("redir", 32'h0, 32'h0, 1'b0, 32'h14);
    stall = 1'b0;
    redirect = 1'b0;
    step();
    check_ifid("redir_ld", 32'h018A5820, 32'h18, 1'b1, 32'h18);

    redirect = 1'b1;
    redirect_pc = 32'h16;
    step();
    check("mis_fault", {31'h0, misaligned_fault}, 32'h1);
    check_ifid("mis", 32'h33333333, 32'h1C, 1'b1, 32'h1C);
    redirect = 1'b0;
    step();
    check("mis_sticky", {31'h0, misaligned_fault}, 32'h1);
    check_ifid("mis_next", 32'h44444444, 32'h20, 1'b1, 32'h20);

    stall = 1'b1;
    flush = 1'b1;
    step();
    check_ifid("stfl", 32'h0, 32'h0, 1'b0, 32'h20);
    stall = 1'b0;
    step();
    check_ifid("flush", 32'h0, 32'h0, 1'b0, 32'h24);
    flush = 1'b0;

    // Out-of-range fetch: word straddling the array end reads as zero.
    redirect = 1'b1;
    redirect_pc = 32'hFC;
    step();
    redirect = 1'b0;
    set_word(32'hFC, 32'hCAFEF00D);
    step();
    check_ifid("last_word", 32'hCAFEF00D, 32'h100, 1'b1, 32'h100);
    step();
    check_ifid("past_end", 32'h0, 32'h104, 1'b1, 32'h104);

    // Mid-cycle reset, then the NOP-run program.
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("rst2");
    clear_mem();
    set_word(32'h0C, 32'h018A5820);
    @(negedge clk) reset = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      step();
      check_ifid("nop", 32'h0, 32'(4 * i), 1'b1, 32'(4 * i));
      check("nop_halted", {31'h0, halted}, 32'h0);
    end
    step();
    check_ifid("add", 32'h018A5820, 32'h10, 1'b1, 32'h10);
    check("add_halted", {31'h0, halted}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("run_halted", {31'h0, halted}, 32'h0);
    end
    check("pre_halt_pc", pc, 32'h1C);
    step();
    check("halt_rise", {31'h0, halted}, 32'h1);
    check_ifid("halt_edge", 32'h0, 32'h20, 1'b1, 32'h20);

    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    check_ifid("halt_redir", 32'h0, 32'h0, 1'b0, 32'h20);
    redirect_pc = 32'h42;
    step();
    check("halt_nofault", {31'h0, misaligned_fault}, 32'h0);
    check("halt_hold", {31'h0, halted}, 32'h1);
    check("halt_pc", pc, 32'h20);
    redirect = 1'b0;

    #2;
    reset = 1'b0;
    #1;
    check_reset_state("rst3");
    set_word(32'h00, 32'hAABBCCDD);
    @(negedge clk) reset = 1'b1;
    step();
    check_ifid("restart", 32'hAABBCCDD, 32'h4, 1'b1, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Front end of the MIPS core, directly upstream of the decode/execute datapath in main.
- Owns the program counter.
- Assembles 32-bit instructions from the byte-wide instruction memory array.
- Presents them through an IF/ID pipeline register with valid, stall, flush and redirect control.
- Detects a run of consecutive NOP fetches and halts fetch, replacing the bench-side NOP counting.

Parameters:
MEM_BYTES, 256, size of instruction_mem in bytes
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
NOP_HALT_COUNT, 4, consecutive all-zero fetched words that trigger halt (1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
instruction_mem  input  8 x MEM_BYTES (unpacked)  byte-addressed instruction store
stall  input  1  hold PC and IF/ID this cycle
flush  input  1  load a bubble into IF/ID this cycle
redirect  input  1  load PC from redirect_pc (branch/jump taken)
redirect_pc  input  32  redirect target
pc  output  32  current fetch address
next_instruction  output  32  IF/ID instruction word
if_id_pc_plus4  output  32  IF/ID PC+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch halted by NOP run
misaligned_fault  output  1  sticky: redirect to non-word-aligned target seen

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC.
  - next_instruction=0, if_id_pc_plus4=0, if_id_valid=0.
  - halted=0, misaligned_fault=0.
  - NOP counter=0, state=RUN.
- Fetch word, combinational from pc:
  - Little-endian: {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}.
  - If pc+3 >= MEM_BYTES, the word is 32'h0.
- States are RUN and HALT. Priority per rising edge in RUN, highest first:
  - 1) redirect=1 with redirect_pc[1:0]==0:
    - pc<=redirect_pc.
    - IF/ID<=bubble (instr=0, pc_plus4=0, valid=0). Overrides stall.
    - NOP counter<=0.
  - 2) redirect=1 with redirect_pc[1:0]!=0:
    - Redirect ignored; misaligned_fault<=1 (sticky until reset).
    - Remaining inputs are processed as if redirect=0.
  - 3) stall=1: pc, IF/ID and NOP counter hold. If flush=1 too, IF/ID<=bubble and pc holds.
  - 4) flush=1 (no stall): IF/ID<=bubble; pc<=pc+4; fetched word is discarded and not counted.
  - 5) Normal advance:
    - next_instruction<=fetch word; if_id_pc_plus4<=pc+4; if_id_valid<=1; pc<=pc+4.
- Fetch latency: the word at address A appears on next_instruction one clock after pc==A, with an unstalled edge.
- NOP counter (4-bit):
  - Increments on each normal-advance load of a 32'h0 word.
  - Clears on a load of any nonzero word.
  - When an increment makes it reach NOP_HALT_COUNT: on that edge, state<=HALT and halted<=1. The final NOP is still loaded into IF/ID.
- HALT:
  - pc frozen.
  - Every edge loads a bubble into IF/ID.
  - stall, flush and redirect are ignored; misaligned_fault does not update.
  - Exit only by reset.
- PC arithmetic is 32-bit modulo 2^32.
- The fetch address is not bounded to memory. Past MEM_BYTES the fetched word is 0, so a NOP run halts the core.
- Reset asserted mid-cycle: all registers clear immediately, without waiting for clk. The first fetch after release is from RESET_PC on the first rising edge with reset=1.

Test Plan:
- Reset then run with mem[3:0]=20,0a,00,0a (mem[3]=0x20) and mem[7:4]=20,0c,00,0b: after edge 1, next_instruction=0x200A000A, if_id_pc_plus4=4, valid=1. After edge 2, next_instruction=0x200C000B, pc=8.
- stall=1 for 3 edges after pc=8: pc stays 8 and IF/ID stays 0x200C000B/8/valid. On release, the next edge loads mem[11:8].
- redirect=1 with redirect_pc=0x14 while stall=1: pc=0x14, IF/ID bubble (valid=0). Next edge loads word 0x018A5820 with if_id_pc_plus4=0x18.
- redirect_pc=0x16: misaligned_fault=1 stays set, pc advances by 4, no bubble.
- Program of 3 NOPs, then add (0x018A5820), then zeros to end of memory:
  - Counter clears at the add; halted rises on the edge that loads the 4th consecutive zero word.
  - pc freezes; valid=0 on following edges; redirect is ignored.
- Drive reset=0 between clock edges while halted: all outputs return to reset values immediately. After release, fetch restarts at RESET_PC=0.
